// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared types for the MIPS pipeline hazard/control unit
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/mips_pipe_ctrl_if.sv
// rtl/mips_pipe_ctrl_if.sv - stage status inputs and control outputs of the pipeline control unit
interface mips_pipe_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             id_rs_used;
    logic             id_rt_used;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             ex_valid;
    logic             ex_wen;
    logic             ex_is_load;
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;
    logic [REG_W-1:0] ex_rd;
    logic             ex_multi_start;
    logic             branch_taken;
    logic             mem_valid;
    logic             mem_wen;
    logic [REG_W-1:0] mem_rd;
    logic             wb_wen;
    logic [REG_W-1:0] wb_rd;

    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             bubble_ex;
    logic             bubble_mem;
    logic             flush_if_id;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             ex_done;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline side: reports stage contents, consumes controls.
    modport master (
        output id_valid, id_rs_used, id_rt_used, id_rs, id_rt,
               ex_valid, ex_wen, ex_is_load, ex_rs, ex_rt, ex_rd,
               ex_multi_start, branch_taken, mem_valid, mem_wen, mem_rd,
               wb_wen, wb_rd,
        input  stall_if, stall_id, stall_ex, bubble_ex, bubble_mem,
               flush_if_id, fwd_a, fwd_b, ex_done, busy, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs_used, id_rt_used, id_rs, id_rt,
               ex_valid, ex_wen, ex_is_load, ex_rs, ex_rt, ex_rd,
               ex_multi_start, branch_taken, mem_valid, mem_wen, mem_rd,
               wb_wen, wb_rd,
        output stall_if, stall_id, stall_ex, bubble_ex, bubble_mem,
               flush_if_id, fwd_a, fwd_b, ex_done, busy, stall_cnt
    );
endinterface

// File: rtl/mips_fwd_sel.sv
// rtl/mips_fwd_sel.sv - per-operand forwarding source comparator
module mips_fwd_sel
    import mips_pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic             mem_valid,
    input  logic             mem_wen,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_wen,
    input  logic [REG_W-1:0] wb_rd,
    output fwd_sel_t         sel
);
    // MEM holds the younger result, so it is checked last and wins.
    always_comb begin
        sel = FWD_RF;
        if (wb_wen && (wb_rd != '0) && (wb_rd == src))
            sel = FWD_WB;
        if (mem_valid && mem_wen && (mem_rd != '0) && (mem_rd == src))
            sel = FWD_MEM;
    end
endmodule

// File: rtl/mips_pipe_ctrl.sv
// rtl/mips_pipe_ctrl.sv - hazard detection, forwarding, multi-cycle EX stall FSM and stall counter
module mips_pipe_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic     clk,
    input  logic     rst,
    mips_pipe_if.slave p
);
    localparam int            CW       = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 2);

    mc_state_t        state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [CNT_W-1:0] stall_cnt_q;
    fwd_sel_t         sel_a, sel_b;

    logic mc_stall, done_c, load_use, branch;
    logic stall_if_c, stall_ex_c, bubble_ex_c, bubble_mem_c, flush_c;

    mips_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .src(p.ex_rs), .mem_valid(p.mem_valid), .mem_wen(p.mem_wen), .mem_rd(p.mem_rd),
        .wb_wen(p.wb_wen), .wb_rd(p.wb_rd), .sel(sel_a)
    );

    mips_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .src(p.ex_rt), .mem_valid(p.mem_valid), .mem_wen(p.mem_wen), .mem_rd(p.mem_rd),
        .wb_wen(p.wb_wen), .wb_rd(p.wb_rd), .sel(sel_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            stall_cnt_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (stall_if_c && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mc_stall  = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (p.ex_multi_start) begin
                    mc_stall  = 1'b1;
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    mc_stall = 1'b1;
                    cnt_nxt  = cnt - CW'(1);
                end else begin
                    done_c    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Hazards only matter while no multi-cycle op owns EX.
        load_use = (state == IDLE) && p.id_valid && p.ex_valid && p.ex_is_load &&
                   (p.ex_rd != '0) &&
                   ((p.id_rs_used && (p.id_rs == p.ex_rd)) ||
                    (p.id_rt_used && (p.id_rt == p.ex_rd)));
        branch   = (state == IDLE) && p.branch_taken;

        // A taken branch squashes the dependent ID instruction, so no stall is needed.
        stall_if_c   = mc_stall || (load_use && !branch);
        stall_ex_c   = mc_stall;
        bubble_ex_c  = load_use || branch;
        bubble_mem_c = mc_stall;
        flush_c      = branch;
    end

    assign p.stall_if    = rst && stall_if_c;
    assign p.stall_id    = rst && stall_if_c;
    assign p.stall_ex    = rst && stall_ex_c;
    assign p.bubble_ex   = rst && bubble_ex_c;
    assign p.bubble_mem  = rst && bubble_mem_c;
    assign p.flush_if_id = rst && flush_c;
    assign p.fwd_a       = rst ? sel_a : FWD_RF;
    assign p.fwd_b       = rst ? sel_b : FWD_RF;
    assign p.ex_done     = rst && done_c;
    assign p.busy        = rst && (state == BUSY);
    assign p.stall_cnt   = stall_cnt_q;
endmodule

// File: doc/mips_pipe_ctrl.md
# mips_pipe_ctrl

Parametrised hazard and pipeline-control unit for the 5-stage MIPS core (IF/ID/EX/MEM/WB). Generates operand-forwarding selects, load-use stalls, branch flushes and multi-cycle EX-operation stalls that the baseline pipeline lacks. Sits beside the stage modules in the CPU top level and drives their stall/bubble/flush controls. Also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- REG_W, 5, register-address width.
- MUL_LAT, 4, total EX occupancy in cycles of a multi-cycle op; legal range ≥2.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock; the only clock.
- rst  in  1  reset, asynchronous, active-low.
- id_valid, id_rs_used, id_rt_used  in  1 each  ID instruction valid / reads rs / reads rt.
- id_rs, id_rt  in  REG_W  ID source registers.
- ex_valid, ex_wen, ex_is_load  in  1 each  EX instruction valid / writes rd / is a load.
- ex_rs, ex_rt, ex_rd  in  REG_W  EX source and destination registers.
- ex_multi_start  in  1  EX holds a multi-cycle op, first cycle.
- branch_taken  in  1  branch resolved taken in EX.
- mem_valid, mem_wen  in  1 each; mem_rd  in  REG_W.
- wb_wen  in  1; wb_rd  in  REG_W.
- stall_if, stall_id, stall_ex  out  1 each  hold the PC, IF/ID and ID/EX registers.
- bubble_ex, bubble_mem  out  1 each  load a NOP into ID/EX or EX/MEM.
- flush_if_id  out  1  squash the IF/ID contents.
- fwd_a, fwd_b  out  2 each  EX operand source: 0 = register file, 1 = MEM, 2 = WB.
- ex_done  out  1  multi-cycle result is valid this cycle.
- busy  out  1  FSM is in BUSY.
- stall_cnt  out  CNT_W  stall-cycle count.

## Operation
Forwarding (combinational, evaluated per operand):
- fwd_a = 1 if mem_valid & mem_wen & mem_rd≠0 & mem_rd==ex_rs.
- else fwd_a = 2 if wb_wen & wb_rd≠0 & wb_rd==ex_rs.
- else fwd_a = 0.
- MEM has priority over WB. fwd_b is the same using ex_rt.

Load-use hazard:
- Condition: id_valid & ex_valid & ex_is_load & ex_rd≠0 & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
- Response: stall_if = stall_id = bubble_ex = 1 for that cycle. This repeats each cycle the condition holds; in practice one cycle.

Branch:
- branch_taken in IDLE gives flush_if_id = bubble_ex = 1.
- Branch outranks load-use: stall_if and stall_id stay 0, because the dependent ID instruction is squashed.

Multi-cycle FSM, states IDLE and BUSY, with down-counter cnt:
- IDLE & ex_multi_start:
  - Assert stall_if, stall_id, stall_ex and bubble_mem in the same cycle.
  - Next state BUSY, cnt ← MUL_LAT-2.
- BUSY & cnt≠0: assert the same four signals, cnt ← cnt-1.
- BUSY & cnt==0: ex_done = 1, no stalls; next state IDLE.
- In BUSY, branch_taken and load-use are ignored; bubble_ex and flush_if_id are 0.
- ex_multi_start in BUSY is ignored.

Stall counter:
- stall_cnt increments on each cycle with stall_if = 1.
- It saturates at all-ones; no wrap.

## Timing
- ex_multi_start sampled at cycle t: stalls asserted in cycles t … t+MUL_LAT-2; ex_done at t+MUL_LAT-1; stalls low in that cycle.
- A new ex_multi_start at t+MUL_LAT is accepted normally (back-to-back ops).
- All hazard and forward outputs are combinational from the inputs plus state, so they resolve within the same cycle. No registered output latency except busy, ex_done and stall_cnt.
- Reset (rst = 0), asynchronous:
  - state → IDLE, cnt → 0, stall_cnt → 0.
  - All stall, bubble and flush outputs, ex_done, busy and fwd_a/fwd_b are forced to 0 regardless of inputs.
- Reset mid-BUSY aborts the op: no ex_done is emitted, and stalls drop immediately.
- The register-0 destination never forwards and never stalls.

## Structure
- Shared package mips_pipe_pkg holds:
  - fwd_sel_t enum: FWD_RF = 0, FWD_MEM = 1, FWD_WB = 2.
  - mc_state_t enum: IDLE, BUSY.
- Sub-module mips_fwd_sel: per-operand forwarding comparator, instantiated twice (A, B).
- FSM, counters and hazard priority logic live in mips_pipe_ctrl.

## Test plan
- Forwarding:
  - ex_rs = 3, mem_rd = 3 (mem_wen = 1), wb_rd = 3 (wb_wen = 1) → fwd_a = 1.
  - Drop mem_wen → fwd_a = 2.
  - Set ex_rs = 0 with all destinations 0 → fwd_a = 0.
- Load-use: ex_is_load = 1, ex_rd = 5, id_rt = 5, id_rt_used = 1 → one cycle of stall_if = stall_id = bubble_ex = 1, stall_cnt = 1.
- Branch plus load-use in the same cycle → flush_if_id = bubble_ex = 1, stall_if = 0, stall_cnt unchanged.
- MUL_LAT = 4, ex_multi_start pulse at t → stalls in t, t+1, t+2; ex_done at t+3; stall_cnt = 3. A branch_taken injected at t+1 → no flush.
- Reset mid-op: rst low at t+1 of a MUL_LAT = 4 op → outputs 0 at once, busy = 0. After release, no ex_done appears and stall_cnt = 0.
- Saturation: CNT_W = 4, hold load-use for 20 cycles → stall_cnt stays at 15.
